store_merge: RTL
================

# store_merge

Sub-word store unit for the multicycle datapath. It narrows a 32-bit register operand to byte/halfword/word and writes it into a word-wide, byte-enable-less data memory, using read-modify-write for SB/SH. It is the store-side counterpart of immediate/load extension: it truncates and inserts where extension widens. It sits between the datapath's MDR/ALUOut registers and the data memory port, and the controller sequences it with a start/done handshake.

## Interface
Parameters:
- `AW`, 32, byte-address width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `size`  in  2  store size code: `STOP_W`=2'b00, `STOP_H`=2'b01, `STOP_B`=2'b10, 2'b11 reserved.
- `addr`  in  AW  byte address (ALUOut).
- `wdata`  in  32  register operand (rt).
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at completion (success or error).
- `err`  out  1  one-cycle pulse with `done` on misalignment or reserved size.
- `mem_addr`  out  AW  word-aligned address {addr[AW-1:2],2'b00}.
- `mem_rd`  out  1  memory read strobe.
- `mem_rdata`  in  32  read data, valid the cycle after `mem_rd`.
- `mem_wr`  out  1  memory write strobe.
- `mem_wdata`  out  32  word to write.

## Operation
- Byte order is little-endian: lane k = bits [8k+7:8k], selected by addr[1:0].
- On `start` in IDLE: latch size, addr and wdata into internal registers. All later cycles use only the latched copies.
- Alignment: SH requires addr[0]=0. SW requires addr[1:0]=0. A violation, or size 2'b11, takes the ERR path.
- States and transitions:
  - IDLE: start & SW & aligned -> WRITE; start & (SB|SH) & aligned -> READ; start & bad -> ERR; otherwise stay.
  - READ: `mem_rd`=1 -> CAPT.
  - CAPT: register merge(mem_rdata, wdata, lane) into the write buffer -> WRITE.
  - WRITE: `mem_wr`=1, `done`=1 -> IDLE.
  - ERR: `done`=1, `err`=1, no memory strobes -> IDLE.
- Merge rules:
  - SB: replace lane addr[1:0] with wdata[7:0].
  - SH: replace lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW: buffer = wdata, no read.
- `mem_addr` is driven from the latched address whenever `busy`, and is 0 in IDLE.
- `start` while busy is ignored: it is not queued and does not disturb the operation in flight.

## Timing
- Reset values: state=IDLE; busy, done, err, mem_rd and mem_wr all 0; mem_addr, mem_wdata and internal buffers all 0.
- Reset takes effect asynchronously: asserting `rstn`=0 mid-operation (any state) drops `mem_wr`/`mem_rd` immediately. No partial write completes, and there is no `done` for the aborted request.
- All outputs are registered-state decodes; there are no combinational paths from inputs to outputs.
- Latency, counted from the `start` edge as cycle 0:
  - SW: WRITE+done in cycle 1.
  - SB/SH: READ in cycle 1, CAPT in cycle 2, WRITE+done in cycle 3.
  - Error: ERR in cycle 1.
- The earliest accepted back-to-back `start` is in the cycle after `done` (IDLE again).
- `mem_wdata` is stable for the whole WRITE cycle.

## Structure
- Add the size codes `STOP_W`/`STOP_H`/`STOP_B` and the state encodings to the shared `ctrl_def.v`, next to the EXTOP codes.
- One combinational sub-module, `st_lane_merge` (inputs: old word, wdata, size, addr[1:0]; output: merged word), reused by the load-side checks in verification.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF -> cycle 1: mem_wr=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, done=1; mem_rd never asserted.
- SB addr 0x13, wdata 0x123456AA, memory word 0x11223344 -> cycle 1 mem_rd=1, cycle 3 mem_wdata=0xAA223344, done=1.
- SH addr 0x12, wdata 0x0000BEEF, memory 0x11223344 -> cycle 3 mem_wdata=0xBEEF3344; SH addr 0x10 -> 0x1122BEEF.
- SH addr 0x11, and SW addr 0x12 -> cycle 1 done=1, err=1; mem_rd/mem_wr stay 0; size 2'b11 behaves the same.
- SB started, `rstn` pulled low during CAPT -> mem_wr never asserts, all outputs 0 immediately; next SW after release completes normally.
- SB in flight, `start` pulsed in READ with SW 0xFFFFFFFF -> ignored; only the SB write occurs, done pulses once.

Source files
------------

// File: rtl/store_merge_pkg.sv
// Shared definitions for the sub-word store unit: store size codes, FSM states
// and the alignment rule.
package store_merge_pkg;

    typedef enum logic [1:0] {
        STOP_W   = 2'b00,
        STOP_H   = 2'b01,
        STOP_B   = 2'b10,
        STOP_RSV = 2'b11
    } stop_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_WRITE,
        ST_ERR
    } state_e;

    // True when the request must take the error path (misaligned or reserved size).
    function automatic logic store_bad(input stop_e size, input logic [1:0] lane);
        case (size)
            STOP_W:  return lane != 2'b00;
            STOP_H:  return lane[0];
            STOP_B:  return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_merge_lane.sv
// Combinational lane insert: writes the narrowed operand into the old memory word
// at the little-endian lane(s) selected by the low address bits.
module st_lane_merge
    import store_merge_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  stop_e       size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            STOP_W: merged = wdata;
            STOP_H: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            STOP_B:  merged[{lane, 3'b000} +: 8] = wdata[7:0];
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_merge.sv
// Sub-word store unit: SW writes directly, SB/SH do read-modify-write on a
// word-wide memory without byte enables. Start/done handshake with the controller.
module store_merge
    import store_merge_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [1:0]    size,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [31:0]   mem_rdata,
    output logic          mem_wr,
    output logic [31:0]   mem_wdata
);

    state_e        state;
    state_e        state_nx;
    stop_e         size_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wbuf;
    logic [31:0]   merged;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (store_bad(stop_e'(size), addr[1:0])) state_nx = ST_ERR;
                    else if (stop_e'(size) == STOP_W)        state_nx = ST_WRITE;
                    else                                     state_nx = ST_READ;
                end
            end
            ST_READ:  state_nx = ST_CAPT;
            ST_CAPT:  state_nx = ST_WRITE;
            ST_WRITE: state_nx = ST_IDLE;
            ST_ERR:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // wbuf holds the raw operand until CAPT, then the merged word to be written.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            size_q <= STOP_W;
            addr_q <= '0;
            wbuf   <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                size_q <= stop_e'(size);
                addr_q <= addr;
                wbuf   <= wdata;
            end else if (state == ST_CAPT) begin
                wbuf <= merged;
            end
        end
    end

    st_lane_merge u_merge (
        .old_word (mem_rdata),
        .wdata    (wbuf),
        .size     (size_q),
        .lane     (addr_q[1:0]),
        .merged   (merged)
    );

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_WRITE) || (state == ST_ERR);
    assign err       = (state == ST_ERR);
    assign mem_rd    = (state == ST_READ);
    assign mem_wr    = (state == ST_WRITE);
    assign mem_addr  = busy ? {addr_q[AW-1:2], 2'b00} : '0;
    assign mem_wdata = wbuf;

endmodule
